// File: rtl/ser_rx.sv
// rtl/ser_rx.sv - serial frame receiver: start/DW data/stop, 2-flop input sync
`timescale 1ns/1ps
module ser_rx #(
  parameter int BIT_CYC = 16,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          sin,
  input  logic          msb_first,
  output logic [DW-1:0] data_out,
  output logic          valid,
  output logic          frame_err,
  output logic          busy
);

  localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] C_HALF = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(BIT_CYC - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic            r_mode;
  logic [DW-1:0]   r_sr;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            w_sin_s;
  logic            w_tick;
  logic            w_half;

  assign w_sin_s   = r_sync2;
  assign w_tick    = (r_cnt == C_LAST);
  assign w_half    = (r_cnt == C_HALF);
  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= sin;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_sin_s) w_next = S_START;
      S_START: if (w_half) w_next = w_sin_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && (r_idx == I_LAST)) w_next = S_STOP;
      S_STOP:  if (w_tick) w_next = w_sin_s ? S_IDLE : S_BREAK;
      S_BREAK: if (w_sin_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Frame datapath; mode is captured at start detection and held for the frame
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_sr    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_sin_s) r_mode <= msb_first;
        end
        S_START: begin
          r_cnt <= w_half ? '0 : r_cnt + 1'b1;
          r_idx <= '0;
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
            r_sr  <= r_mode ? {r_sr[DW-2:0], w_sin_s} : {w_sin_s, r_sr[DW-1:1]};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (w_sin_s) begin
              r_data  <= r_sr;
              r_valid <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/ser_rx.md
Name: ser_rx

Overview:
Serial-to-parallel frame receiver. It is the receiving end of the team's 8-bit shift-register serial path.
- It takes a single-wire stream: idle high, one start bit (0), DW data bits, one stop bit (1).
- Each bit lasts BIT_CYC clocks.
- It rebuilds the data word in an internal shift register and presents it with a one-cycle valid pulse.
- It sits between an external serial pin or a shift-register transmitter and byte-wide consumer logic.

Parameters:
BIT_CYC, 16, clocks per serial bit; even, >= 4.
DW, 8, data bits per frame.

Ports:
clk  input  1  system clock, rising edge.
clrn  input  1  asynchronous active-low reset.
sin  input  1  serial data in; asynchronous to clk.
msb_first  input  1  0 = LSB received first (shift right into bit DW-1); 1 = MSB first (shift left into bit 0).
data_out  output  DW  last correctly framed word; holds until the next good frame.
valid  output  1  one-cycle pulse when data_out updates.
frame_err  output  1  one-cycle pulse when the stop bit samples 0.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: clk and reset are "one clock; reset is asynchronous and active-low".
  - clrn=0 immediately forces state=IDLE and counters=0.
  - Outputs: data_out=0, valid=0, frame_err=0, busy=0.
  - Internal shift register=0; both synchronizer flops=1.
  - Reset mid-frame abandons the frame; no valid or frame_err is produced for it.
- Input sync: sin passes through a 2-flop synchronizer (sin_s). All decisions use sin_s only.
- Let H = BIT_CYC/2. Counter cnt is wide enough for BIT_CYC-1. Bit index idx runs 0..DW-1.
- IDLE:
  - If sin_s==0: go to START, cnt=0, latch msb_first into mode_r.
  - mode_r is used for the whole frame; changing msb_first mid-frame has no effect.
- START:
  - cnt increments each cycle.
  - At cnt==H-1: if sin_s==0, go to DATA with cnt=0, idx=0. Otherwise go to IDLE (glitch rejected; no output activity).
- DATA:
  - cnt increments each cycle. At cnt==BIT_CYC-1, sample sin_s (mid-bit) and set cnt=0.
  - mode_r=0: sr <= {sin_s, sr[DW-1:1]}.
  - mode_r=1: sr <= {sr[DW-2:0], sin_s}.
  - On the sample with idx==DW-1, go to STOP. Otherwise idx++.
- STOP: at cnt==BIT_CYC-1, sample sin_s.
  - sin_s==1: data_out<=sr, valid=1 for one cycle, go to IDLE.
  - sin_s==0: frame_err=1 for one cycle, data_out unchanged, go to BREAK.
- BREAK: wait until sin_s==1, then go to IDLE. A line held low never retriggers a frame.
- valid and frame_err are registered, mutually exclusive, and never high for two consecutive cycles from one frame.
- Latency: let k0 be the first clk edge at which sin is sampled low by the first sync flop. valid or frame_err rises at edge k0 + 2 + H + (DW+1)*BIT_CYC.
- Back-to-back frames: a new start bit may begin immediately after the stop bit. IDLE is re-entered mid-stop-bit, so the next falling edge is detected normally.
- busy=1 in START, DATA, STOP and BREAK.

Test Plan:
1. Reset then idle: clrn low for 3 cycles, sin=1 for 200 cycles (BIT_CYC=4) -> data_out=0, valid=0, frame_err=0, busy=0 throughout.
2. LSB-first frame: BIT_CYC=4, msb_first=0, send 0xA3 (wire order start, 1,1,0,0,0,1,0,1, stop) -> single valid pulse at edge k0+40, data_out=0xA3, frame_err=0.
3. MSB-first frame: the same wire sequence with msb_first=1 -> data_out=0xC5. Toggling msb_first mid-frame does not change the result.
4. Framing error: send 0x3C with stop bit forced 0, then hold sin=0 for 30 cycles -> frame_err pulse once, data_out keeps its previous value, busy stays high until sin returns to 1, no new frame starts.
5. Glitch and back-to-back: a 1-cycle low pulse on sin -> returns to IDLE, no outputs. Then two consecutive frames 0x01 and 0xFF with no idle gap -> two valid pulses exactly 40 cycles apart, data_out 0x01 then 0xFF.
6. Reset mid-frame: assert clrn during DATA idx=4 -> outputs clear asynchronously, no valid. The next full frame 0x55 is received correctly.
